prog_loader: RTL and testbench

- Byte-stream program loader directly upstream of the unified instruction/data memory.
- Receives a length-prefixed image over a valid/ready byte interface (e.g. from the UART receiver) and assembles 16-bit little-endian words.
- Drives the memory write port (address, write data, write enable) to place consecutive words from BASE_ADDR.
- Raises done when the image is loaded; top level holds the CPU stalled while busy is high.

---
 rtl/prog_loader.sv | 179 +++++++++++++++++
 tb/tb_prog_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader that writes 16-bit little-endian words to memory from BASE_ADDR.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif
`ifndef MEM_LEN
`define MEM_LEN 256
`endif

module prog_loader #(
  parameter logic [`REG_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned           MAX_WORDS = `MEM_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [`REG_WIDTH-1:0]  mem_addr,
  output logic [`WORD_WIDTH-1:0] mem_wdata,
  output logic                   mem_we,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [`REG_WIDTH-1:0]  words_loaded
);

  localparam int unsigned RW = `REG_WIDTH;
  localparam int unsigned WW = `WORD_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DAT_LO,
    S_DAT_HI,
    S_DONE,
`ifdef LOADER_CHECKSUM_EN
    S_ERR,
    S_CHK
`else
    S_ERR
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t          state_q, state_d;
  logic [7:0]      cnt_lo_q, cnt_lo_d;
  logic [15:0]     rem_q, rem_d;
  logic [7:0]      lo_q, lo_d;
  logic [RW-1:0]   wl_q, wl_d;
  logic [RW-1:0]   addr_q, addr_d;
  logic [WW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            accept;
  logic [15:0]     full_cnt;

`ifdef LOADER_CHECKSUM_EN
  assign rx_ready = state_q inside {S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI, S_CHK};
`else
  assign rx_ready = state_q inside {S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI};
`endif
  assign busy         = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = wl_q;

  assign accept   = rx_valid && rx_ready;
  assign full_cnt = {rx_data, cnt_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    rem_d    = rem_q;
    lo_d     = lo_q;
    wl_d     = wl_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    if (accept && state_q != S_CHK) csum_d = csum_q ^ rx_data;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          wl_d    = '0;
          rem_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          cnt_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          rem_d = full_cnt;
          if ({16'd0, full_cnt} > MAX_WORDS) state_d = S_ERR;
          else if (full_cnt == 16'd0)        state_d = S_END;
          else                               state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        // Address uses the pre-increment count; both land on the same edge as mem_we.
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + wl_q;
          wdata_d = WW'({rx_data, lo_q});
          wl_d    = wl_q + RW'(1);
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_END : S_DAT_LO;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_lo_q <= '0;
      rem_q    <= '0;
      lo_q     <= '0;
      wl_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      rem_q    <= rem_d;
      lo_q     <= lo_d;
      wl_q     <= wl_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (BASE 0 / default MAX, BASE 0x10 / MAX 4) share the byte stream.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module tb_prog_loader;

  logic clk = 1'b0;
  logic rst_n, start, rx_valid;
  logic [7:0] rx_data;

  logic                   m0_rdy, m0_we, m0_busy, m0_done, m0_err;
  logic [`REG_WIDTH-1:0]  m0_addr, m0_wl;
  logic [`WORD_WIDTH-1:0] m0_wdata;
  logic                   m1_rdy, m1_we, m1_busy, m1_done, m1_err;
  logic [`REG_WIDTH-1:0]  m1_addr, m1_wl;
  logic [`WORD_WIDTH-1:0] m1_wdata;

  int checks = 0;
  int errors = 0;
  int wr0 = 0;
  int wr1 = 0;
  int wbase;

  always #5 clk = ~clk;

  prog_loader u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(m0_rdy), .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_we(m0_we),
    .busy(m0_busy), .done(m0_done), .err(m0_err), .words_loaded(m0_wl)
  );

  prog_loader #(.BASE_ADDR(`REG_WIDTH'('h10)), .MAX_WORDS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(m1_rdy), .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we),
    .busy(m1_busy), .done(m1_done), .err(m1_err), .words_loaded(m1_wl)
  );

  always @(posedge clk) begin
    if (m0_we) wr0 <= wr0 + 1;
    if (m1_we) wr1 <= wr1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    start    = s;
    rx_valid = v;
    rx_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
    chk("rst_rdy",   m1_rdy,   0);
    chk("rst_we",    m1_we,    0);
    chk("rst_addr",  m1_addr,  0);
    chk("rst_wdata", m1_wdata, 0);
    chk("rst_busy",  m1_busy,  0);
    chk("rst_done",  m1_done,  0);
    chk("rst_err",   m1_err,   0);
    chk("rst_wl",    m1_wl,    0);
    rst_n = 1'b1;

    // Reset mid-load on u0 (BASE 0)
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h03);
    chk("rml_rdy",  m0_rdy,  1);
    chk("rml_busy", m0_busy, 1);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'h34);
    tick(0, 1, 8'h12);
    tick(0, 1, 8'h78);
    rst_n = 1'b0;
    chk("rml_we",    m0_we,    1);
    chk("rml_addr",  m0_addr,  0);
    chk("rml_wdata", m0_wdata, 16'h1234);
    chk("rml_wl",    m0_wl,    1);
    tick(0, 1, 8'h56);
    rst_n = 1'b1;
    chk("rml_r_we",    m0_we,    0);
    chk("rml_r_addr",  m0_addr,  0);
    chk("rml_r_wdata", m0_wdata, 0);
    chk("rml_r_wl",    m0_wl,    0);
    chk("rml_r_busy",  m0_busy,  0);
    chk("rml_r_rdy",   m0_rdy,   0);
    chk("rml_r_done",  m0_done,  0);
    chk("rml_r_err",   m0_err,   0);
    tick(0, 1, 8'h9A);
    tick(0, 0, 8'h00);
    chk("rml_nwrites", wr0, 1);
    chk("rml_idle_we", m0_we, 0);

    // Basic load on u1 (BASE 0x10)
    wbase = wr1;
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h02);
    chk("bas_rdy",  m1_rdy,  1);
    chk("bas_busy", m1_busy, 1);
    chk("bas_wl0",  m1_wl,   0);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'hCD);
    tick(0, 1, 8'hAB);
    tick(0, 1, 8'h01);
    chk("bas_we0",   m1_we,    1);
    chk("bas_addr0", m1_addr,  16'h0010);
    chk("bas_data0", m1_wdata, 16'hABCD);
    chk("bas_wl1",   m1_wl,    1);
    tick(0, 1, 8'h00);
    chk("bas_gapwe",  m1_we,   0);
    chk("bas_hold",   m1_addr, 16'h0010);
`ifdef LOADER_CHECKSUM_EN
    tick(0, 1, 8'h65);
    chk("bas_we1",   m1_we,    1);
    chk("bas_addr1", m1_addr,  16'h0011);
    chk("bas_data1", m1_wdata, 16'h0001);
    chk("bas_chkbusy", m1_busy, 1);
    tick(0, 1, 8'hEE);
    chk("bas_done",  m1_done,  1);
    chk("bas_wl2",   m1_wl,    2);
`else
    tick(0, 1, 8'hEE);
    chk("bas_we1",   m1_we,    1);
    chk("bas_addr1", m1_addr,  16'h0011);
    chk("bas_data1", m1_wdata, 16'h0001);
    chk("bas_done",  m1_done,  1);
    chk("bas_wl2",   m1_wl,    2);
`endif
    chk("bas_err",  m1_err,  0);
    chk("bas_busy0", m1_busy, 0);
    tick(0, 1, 8'hEE);
    chk("bas_rdy0",  m1_rdy,  0);
    chk("bas_held",  m1_done, 1);
    tick(0, 0, 8'h00);
    chk("bas_nwrites", wr1 - wbase, 2);

    // Zero length, started from DONE
    wbase = wr1;
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h00);
    chk("zl_doneclr", m1_done, 0);
    tick(0, 1, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    tick(0, 1, 8'h00);
    chk("zl_chk", m1_busy, 1);
`endif
    tick(0, 0, 8'h00);
    chk("zl_done", m1_done, 1);
    chk("zl_wl",   m1_wl,   0);
    chk("zl_err",  m1_err,  0);
    chk("zl_nwr",  wr1 - wbase, 0);

    // Over-length: 5 words against MAX_WORDS=4
    wbase = wr1;
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h05);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'h77);
    chk("ol_err",  m1_err,  1);
    chk("ol_done", m1_done, 0);
    chk("ol_busy", m1_busy, 0);
    chk("ol_rdy",  m1_rdy,  0);
    tick(0, 1, 8'h77);
    chk("ol_hold", m1_err, 1);
    chk("ol_nwr",  wr1 - wbase, 0);
    tick(1, 0, 8'h00);
    tick(0, 0, 8'h00);
    chk("ol_clr",     m1_err,  0);
    chk("ol_restart", m1_rdy,  1);
    tick(0, 0, 8'h00);
    rst_n = 1'b0;
    tick(0, 0, 8'h00);
    rst_n = 1'b1;

    // Stalled source with start pulses while busy
    wbase = wr1;
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h02);
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
    tick(0, 1, 8'h00);
    tick(1, 0, 8'h00);
    tick(0, 1, 8'hCD);
    chk("st_busy", m1_busy, 1);
    chk("st_wl0",  m1_wl,   0);
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
    tick(0, 1, 8'hAB);
    tick(1, 0, 8'h00);
    chk("st_we0",   m1_we,    1);
    chk("st_addr0", m1_addr,  16'h0010);
    chk("st_data0", m1_wdata, 16'hABCD);
    tick(0, 0, 8'h00);
    chk("st_gapwe", m1_we, 0);
    tick(0, 1, 8'h01);
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
    tick(0, 1, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    tick(0, 1, 8'h65);
    chk("st_we1",   m1_we,    1);
    chk("st_addr1", m1_addr,  16'h0011);
    chk("st_data1", m1_wdata, 16'h0001);
    tick(0, 0, 8'h00);
`else
    tick(0, 0, 8'h00);
    chk("st_we1",   m1_we,    1);
    chk("st_addr1", m1_addr,  16'h0011);
    chk("st_data1", m1_wdata, 16'h0001);
`endif
    chk("st_done", m1_done, 1);
    chk("st_wl2",  m1_wl,   2);
    tick(0, 0, 8'h00);
    chk("st_nwr", wr1 - wbase, 2);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good: 01^00^FF^00 = FE
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h01);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'hFF);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'hFE);
    chk("ck_we",   m1_we,    1);
    chk("ck_addr", m1_addr,  16'h0010);
    chk("ck_data", m1_wdata, 16'h00FF);
    chk("ck_rdy",  m1_rdy,   1);
    tick(0, 0, 8'h00);
    chk("ck_done", m1_done, 1);
    chk("ck_err",  m1_err,  0);
    // Checksum bad
    wbase = wr1;
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h01);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'hFF);
    tick(0, 1, 8'h00);
    tick(0, 1, 8'h00);
    chk("ckb_data", m1_wdata, 16'h00FF);
    tick(0, 0, 8'h00);
    chk("ckb_err",  m1_err,  1);
    chk("ckb_done", m1_done, 0);
    chk("ckb_wl",   m1_wl,   1);
    chk("ckb_nwr",  wr1 - wbase, 1);
`endif

    tick(0, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
